// File: rtl/prbs8_checker.sv
// ---------------------------------------------------------------------------
// prbs8_checker
//   Receive-side checker for the degree-8 PRBS (x^8+x^7+x^6+x^5+x^2+x+1).
//   A local 8-bit history self-synchronises to the serial stream. Once
//   LOCK_CNT consecutive bits are predicted correctly it declares lock and
//   flywheels: from then on it shifts its own prediction, so a single
//   corrupted line bit produces exactly one error. Too many errors inside
//   one WIN_LEN-bit window drop lock, and the checker re-acquires.
//
// Ports
//   Clk_CI     in   clock, rising edge
//   Rst_RI     in   asynchronous active-high reset
//   BitVld_SI  in   Bit_DI valid this cycle
//   Bit_DI     in   received PRBS bit
//   Clear_SI   in   synchronous clear of both counters (lock unaffected)
//   Locked_SO  out  high while locked
//   Err_SO     out  one-cycle pulse, previous valid bit was in error
//   ErrCnt_DO  out  saturating errored-bit count while locked
//   BitCnt_DO  out  saturating checked-bit count while locked
// ---------------------------------------------------------------------------
module prbs8_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 BitVld_SI,
    input  logic                 Bit_DI,
    input  logic                 Clear_SI,
    output logic                 Locked_SO,
    output logic                 Err_SO,
    output logic [CNT_WIDTH-1:0] ErrCnt_DO,
    output logic [CNT_WIDTH-1:0] BitCnt_DO
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int WERR_W = $clog2(UNLOCK_ERRS + 1);

    localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]    WERR_LIM = WERR_W'(UNLOCK_ERRS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_hist, w_hist_nxt;     // [0] = newest bit
    logic [2:0]          r_fill, w_fill_nxt;
    logic [RUN_W-1:0]    r_run, w_run_nxt;
    logic [WIN_W-1:0]    r_win, w_win_nxt;
    logic [WERR_W-1:0]   r_werr, w_werr_nxt;
    logic                r_err, w_err_nxt;
    logic [CNT_WIDTH-1:0] r_errcnt, r_bitcnt;
    logic                w_bit_inc, w_err_inc;
    logic                w_pred, w_mis;

    assign w_pred = r_hist[0] ^ r_hist[1] ^ r_hist[4] ^ r_hist[5] ^ r_hist[6] ^ r_hist[7];
    assign w_mis  = Bit_DI ^ w_pred;

    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_run_nxt   = r_run;
        w_win_nxt   = r_win;
        w_werr_nxt  = r_werr;
        w_err_nxt   = 1'b0;
        w_bit_inc   = 1'b0;
        w_err_inc   = 1'b0;
        if (BitVld_SI) begin
            case (r_state)
                S_SEARCH: begin
                    w_hist_nxt = {r_hist[6:0], Bit_DI};
                    if (r_fill == 3'd7) begin
                        w_state_nxt = S_VERIFY;
                        w_run_nxt   = '0;
                        w_fill_nxt  = '0;
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
                S_VERIFY: begin
                    w_hist_nxt = {r_hist[6:0], Bit_DI};
                    w_run_nxt  = w_mis ? '0 : r_run + 1'b1;
                    // An all-zero history is a fixed point of the recurrence;
                    // locking there would accept a dead line.
                    if (w_hist_nxt == 8'h00) begin
                        w_state_nxt = S_SEARCH;
                        w_fill_nxt  = '0;
                    end else if (!w_mis && r_run == RUN_LAST) begin
                        w_state_nxt = S_LOCKED;
                        w_win_nxt   = '0;
                        w_werr_nxt  = '0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: shift the prediction, not the line bit.
                    w_hist_nxt = {r_hist[6:0], w_pred};
                    w_bit_inc  = 1'b1;
                    w_err_inc  = w_mis;
                    w_err_nxt  = w_mis;
                    // At a window boundary this bit's error opens the new window.
                    if (r_win == WIN_LAST) begin
                        w_win_nxt  = '0;
                        w_werr_nxt = {{(WERR_W-1){1'b0}}, w_mis};
                    end else begin
                        w_win_nxt  = r_win + 1'b1;
                        w_werr_nxt = r_werr + {{(WERR_W-1){1'b0}}, w_mis};
                    end
                    if (w_werr_nxt == WERR_LIM) begin
                        w_state_nxt = S_SEARCH;
                        w_fill_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_SEARCH;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_state <= S_SEARCH;
            r_hist  <= '0;
            r_fill  <= '0;
            r_run   <= '0;
            r_win   <= '0;
            r_werr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_run   <= w_run_nxt;
            r_win   <= w_win_nxt;
            r_werr  <= w_werr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_errcnt <= '0;
            r_bitcnt <= '0;
        end else if (Clear_SI) begin
            r_errcnt <= '0;
            r_bitcnt <= '0;
        end else begin
            if (w_bit_inc && r_bitcnt != CNT_MAX) r_bitcnt <= r_bitcnt + 1'b1;
            if (w_err_inc && r_errcnt != CNT_MAX) r_errcnt <= r_errcnt + 1'b1;
        end
    end

    assign Locked_SO = (r_state == S_LOCKED);
    assign Err_SO    = r_err;
    assign ErrCnt_DO = r_errcnt;
    assign BitCnt_DO = r_bitcnt;

endmodule
